// File: rtl/fb_pkg.sv
// rtl/fb_pkg.sv - shared types and elaboration helpers for the frame buffer controller
package fb_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } fb_state_t;

    function automatic int fb_depth(input int h_res, input int v_res);
        return h_res * v_res;
    endfunction

    function automatic bit fb_addr_fits(input int addr_w, input int h_res, input int v_res);
        return (longint'(1) << addr_w) >= longint'(fb_depth(h_res, v_res));
    endfunction

    function automatic int fb_cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fb_dpram.sv
// rtl/fb_dpram.sv - simple dual-port RAM, one write port, registered read-first read port
module fb_dpram #(
    parameter int DATA_W = 3,
    parameter int ADDR_W = 17,
    parameter int DEPTH  = 76800
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic              rd_en_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output logic [DATA_W-1:0] rd_data_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rd_data_q;

    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    // Separate process keeps the array free of reset; the NBA read returns pre-write data.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_data_q <= '0;
        end else if (rd_en_i) begin
            rd_data_q <= mem_q[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/frame_buffer_ctrl.sv
// rtl/frame_buffer_ctrl.sv - frame buffer with write port, clear engine and scaled raster scan-out
module frame_buffer_ctrl
    import fb_pkg::*;
#(
    parameter int H_RES  = 320,
    parameter int V_RES  = 240,
    parameter int PIX_W  = 3,
    parameter int ADDR_W = 17,
    parameter int SCALE  = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              wrValid,
    output logic              wrReady,
    input  logic [ADDR_W-1:0] wrAddr,
    input  logic [PIX_W-1:0]  wrData,
    output logic              wrErr,
    input  logic              clearReq,
    input  logic [PIX_W-1:0]  clearColor,
    output logic              clearBusy,
    input  logic              frameStart,
    input  logic              pixelReq,
    output logic [PIX_W-1:0]  pixelOut,
    output logic              pixelValid
);

    localparam int DEPTH = fb_depth(H_RES, V_RES);
    localparam int SUB_W = fb_cnt_w(SCALE);
    localparam int COL_W = fb_cnt_w(H_RES);
    localparam int ROW_W = fb_cnt_w(V_RES);

    localparam logic [ADDR_W:0]   DEPTH_X   = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] H_STEP    = ADDR_W'(H_RES);
    localparam logic [SUB_W-1:0]  SUB_LAST  = SUB_W'(SCALE - 1);
    localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(H_RES - 1);
    localparam logic [ROW_W-1:0]  ROW_LAST  = ROW_W'(V_RES - 1);

    generate
        if (!fb_addr_fits(ADDR_W, H_RES, V_RES) || SCALE < 1 || SCALE > 4) begin : g_bad_params
            $error("frame_buffer_ctrl: ADDR_W too small for H_RES*V_RES or SCALE outside 1..4");
        end
    endgenerate

    fb_state_t         state_q, state_d;
    logic              rdy_q;
    logic              err_q, err_d;
    logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;
    logic [PIX_W-1:0]  clr_color_q, clr_color_d;

    logic              ram_we;
    logic [ADDR_W-1:0] ram_waddr;
    logic [PIX_W-1:0]  ram_wdata;
    logic              wr_fire;
    logic              wr_in_range;

    assign wrReady     = rdy_q && (state_q == IDLE);
    assign clearBusy   = (state_q == CLEAR);
    assign wrErr       = err_q;
    assign wr_fire     = wrValid && wrReady;
    assign wr_in_range = {1'b0, wrAddr} < DEPTH_X;

    always_comb begin
        state_d     = state_q;
        err_d       = err_q;
        clr_addr_d  = clr_addr_q;
        clr_color_d = clr_color_q;
        ram_we      = 1'b0;
        ram_waddr   = wrAddr;
        ram_wdata   = wrData;
        case (state_q)
            IDLE: begin
                if (wr_fire) begin
                    if (wr_in_range) begin
                        ram_we = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                if (clearReq) begin
                    state_d     = CLEAR;
                    clr_addr_d  = '0;
                    clr_color_d = clearColor;
                end
            end
            CLEAR: begin
                ram_we     = 1'b1;
                ram_waddr  = clr_addr_q;
                ram_wdata  = clr_color_q;
                clr_addr_d = clr_addr_q + 1'b1;
                if (clr_addr_q == LAST_ADDR) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            rdy_q       <= 1'b0;
            err_q       <= 1'b0;
            clr_addr_q  <= '0;
            clr_color_q <= '0;
        end else begin
            state_q     <= state_d;
            rdy_q       <= 1'b1;
            err_q       <= err_d;
            clr_addr_q  <= clr_addr_d;
            clr_color_q <= clr_color_d;
        end
    end

    logic [SUB_W-1:0]  sub_x_q, sub_x_d, cur_sub_x;
    logic [COL_W-1:0]  col_q, col_d, cur_col;
    logic [SUB_W-1:0]  sub_y_q, sub_y_d, cur_sub_y;
    logic [ROW_W-1:0]  row_q, row_d, cur_row;
    logic [ADDR_W-1:0] base_q, base_d, cur_base;
    logic [ADDR_W-1:0] rd_addr;
    logic              pv_q;

    // frameStart zeroes the position the same cycle, so a coincident request reads address 0.
    always_comb begin
        cur_sub_x = frameStart ? '0 : sub_x_q;
        cur_col   = frameStart ? '0 : col_q;
        cur_sub_y = frameStart ? '0 : sub_y_q;
        cur_row   = frameStart ? '0 : row_q;
        cur_base  = frameStart ? '0 : base_q;
        rd_addr   = cur_base + ADDR_W'(cur_col);
        sub_x_d   = cur_sub_x;
        col_d     = cur_col;
        sub_y_d   = cur_sub_y;
        row_d     = cur_row;
        base_d    = cur_base;
        if (pixelReq) begin
            if (cur_sub_x != SUB_LAST) begin
                sub_x_d = cur_sub_x + 1'b1;
            end else begin
                sub_x_d = '0;
                if (cur_col != COL_LAST) begin
                    col_d = cur_col + 1'b1;
                end else begin
                    col_d = '0;
                    if (cur_sub_y != SUB_LAST) begin
                        sub_y_d = cur_sub_y + 1'b1;
                    end else begin
                        sub_y_d = '0;
                        if (cur_row != ROW_LAST) begin
                            row_d  = cur_row + 1'b1;
                            base_d = cur_base + H_STEP;
                        end else begin
                            row_d  = '0;
                            base_d = '0;
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sub_x_q <= '0;
            col_q   <= '0;
            sub_y_q <= '0;
            row_q   <= '0;
            base_q  <= '0;
            pv_q    <= 1'b0;
        end else begin
            sub_x_q <= sub_x_d;
            col_q   <= col_d;
            sub_y_q <= sub_y_d;
            row_q   <= row_d;
            base_q  <= base_d;
            pv_q    <= pixelReq;
        end
    end

    assign pixelValid = pv_q;

    fb_dpram #(
        .DATA_W (PIX_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_ram (
        .clk_i     (clock),
        .rst_i     (reset),
        .wr_en_i   (ram_we),
        .wr_addr_i (ram_waddr),
        .wr_data_i (ram_wdata),
        .rd_en_i   (pixelReq),
        .rd_addr_i (rd_addr),
        .rd_data_o (pixelOut)
    );

endmodule

// File: tb/tb_frame_buffer_ctrl.sv
// tb/tb_frame_buffer_ctrl.sv - randomized model-checked bench for frame_buffer_ctrl
module tb_frame_buffer_ctrl;

    localparam int H = 20, V = 12, S = 2, AW = 8, PW = 3;
    localparam int DEPTH = H * V;
    localparam int RW = H * S, RH = V * S, FRAME = RW * RH;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          wrValid = 1'b0, wrReady, wrErr;
    logic [AW-1:0] wrAddr = '0;
    logic [PW-1:0] wrData = '0, clearColor = '0, pixelOut;
    logic          clearReq = 1'b0, clearBusy, frameStart = 1'b0, pixelReq = 1'b0, pixelValid;

    always #5 clock = ~clock;

    frame_buffer_ctrl #(
        .H_RES(H), .V_RES(V), .PIX_W(PW), .ADDR_W(AW), .SCALE(S)
    ) dut (
        .clock(clock), .reset(reset),
        .wrValid(wrValid), .wrReady(wrReady), .wrAddr(wrAddr), .wrData(wrData), .wrErr(wrErr),
        .clearReq(clearReq), .clearColor(clearColor), .clearBusy(clearBusy),
        .frameStart(frameStart), .pixelReq(pixelReq), .pixelOut(pixelOut), .pixelValid(pixelValid)
    );

    int n_cmp = 0, n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: memory as an array, raster position as plain (x,y) in display pixels.
    int   m_mem [DEPTH];
    bit   m_known [DEPTH];
    logic m_rdy, m_err, m_pv, m_pix_known;
    int   m_pix, m_clr_left, m_clr_idx, m_clr_color, m_rx, m_ry, m_a;
    bit   m_busy, m_ready;

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            m_rdy = 0; m_err = 0; m_pv = 0; m_pix = 0; m_pix_known = 1;
            m_clr_left = 0; m_clr_idx = 0; m_rx = 0; m_ry = 0;
        end else begin
            m_busy  = m_clr_left > 0;
            m_ready = m_rdy && !m_busy;
            if (frameStart) begin m_rx = 0; m_ry = 0; end
            m_pv = pixelReq;
            if (pixelReq) begin
                m_a = (m_ry / S) * H + m_rx / S;
                m_pix = m_mem[m_a];
                m_pix_known = m_known[m_a];
                m_rx++;
                if (m_rx == RW) begin m_rx = 0; m_ry = (m_ry + 1) % RH; end
            end
            if (m_busy) begin
                m_mem[m_clr_idx] = m_clr_color;
                m_known[m_clr_idx] = 1;
                m_clr_idx++;
                m_clr_left--;
            end else begin
                if (wrValid && m_ready) begin
                    if (int'(wrAddr) < DEPTH) begin
                        m_mem[int'(wrAddr)] = int'(wrData);
                        m_known[int'(wrAddr)] = 1;
                    end else begin
                        m_err = 1;
                    end
                end
                if (clearReq) begin
                    m_clr_left = DEPTH; m_clr_idx = 0; m_clr_color = int'(clearColor);
                end
            end
            m_rdy = 1;
        end
    end

    always @(negedge clock) begin
        if (!reset) begin
            chk("wrReady", wrReady, m_rdy && m_clr_left == 0);
            chk("clearBusy", clearBusy, m_clr_left > 0);
            chk("wrErr", wrErr, m_err);
            chk("pixelValid", pixelValid, m_pv);
            if (m_pix_known) chk("pixelOut", pixelOut, m_pix);
        end
    end

    int cap[$];
    always @(negedge clock) begin
        if (!reset && pixelValid) cap.push_back(int'(pixelOut));
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(negedge clock);
    endtask

    task automatic idle_in();
        wrValid = 0; clearReq = 0; frameStart = 0; pixelReq = 0;
    endtask

    task automatic do_write(input int addr, input int data);
        int guard;
        guard = 0;
        wrValid = 1; wrAddr = AW'(addr); wrData = PW'(data);
        while (wrReady !== 1'b1 && guard < 2 * DEPTH) begin tick(); guard++; end
        chk("wr_handshake_timeout", guard < 2 * DEPTH, 1);
        tick();
        wrValid = 0;
    endtask

    task automatic scan(input int n, input bit fs_first, input int gap_pct);
        cap.delete();
        for (int i = 0; i < n; i++) begin
            pixelReq = 1;
            frameStart = fs_first && (i == 0);
            tick();
            pixelReq = 0; frameStart = 0;
            if ($urandom_range(0, 99) < gap_pct) tick();
        end
        repeat (3) tick();
    endtask

    task automatic clear_run(input int color, output int busy_cnt, output int ready_hi);
        int cycles;
        busy_cnt = 0; ready_hi = 0; cycles = 0;
        clearColor = PW'(color); clearReq = 1;
        tick();
        clearReq = 0;
        while (cycles < 4 * DEPTH) begin
            if (clearBusy !== 1'b1) break;
            busy_cnt++;
            if (wrReady !== 1'b0) ready_hi++;
            pixelReq = 1'($urandom_range(0, 1));
            wrValid = 1'($urandom_range(0, 1));
            wrAddr = AW'($urandom_range(0, DEPTH + 15));
            wrData = PW'($urandom);
            clearReq = ($urandom_range(0, 7) == 0);
            clearColor = PW'($urandom);
            tick();
            cycles++;
        end
        idle_in();
        repeat (3) tick();
    endtask

    task automatic check_all(input string name, input int want);
        int bad;
        bad = 0;
        foreach (cap[i]) if (cap[i] != want) bad++;
        chk({name, "_count"}, cap.size(), FRAME);
        chk(name, bad, 0);
    endtask

    int busy_cnt, ready_hi;

    initial begin
        idle_in();
        reset = 1;
        repeat (3) tick();
        chk("rst_wrReady", wrReady, 0);
        chk("rst_wrErr", wrErr, 0);
        chk("rst_clearBusy", clearBusy, 0);
        chk("rst_pixelValid", pixelValid, 0);
        chk("rst_pixelOut", pixelOut, 0);
        reset = 0;
        #1 chk("ready_at_release", wrReady, 0);
        tick();
        chk("ready_after_release", wrReady, 1);

        do_write(0, 5);
        do_write(1 * H + 1, 3);
        tick();
        scan(90, 1, 0);
        chk("scan1_len", cap.size(), 90);
        chk("scan1_x0", cap[0], 5);
        chk("scan1_x1", cap[1], 5);
        chk("scan1_y2x2", cap[2 * RW + 2], 3);
        chk("scan1_y2x3", cap[2 * RW + 3], 3);
        pixelReq = 1; tick(); pixelReq = 0;
        chk("latency_valid", pixelValid, 1);
        tick();
        chk("latency_drop", pixelValid, 0);
        tick();

        clear_run(2, busy_cnt, ready_hi);
        chk("clear_busy_cycles", busy_cnt, DEPTH);
        chk("clear_ready_low", ready_hi, 0);
        scan(FRAME, 1, 10);
        check_all("clear_fill_2", 2);

        do_write(DEPTH, 6);
        tick();
        chk("oor_err", wrErr, 1);
        do_write(255, 1);
        repeat (5) tick();
        chk("oor_err_sticky", wrErr, 1);
        scan(1, 1, 0);
        chk("oor_addr0_kept", cap[0], 2);

        do_write(0, 4);
        do_write(1, 6);
        scan(6 * RW * S / S * 2 + 10 * S, 1, 0);
        scan(3, 1, 0);
        chk("fs_mid_0", cap[0], 4);
        chk("fs_mid_1", cap[1], 4);
        chk("fs_mid_2", cap[2], 6);

        do_write(10, 1);
        scan(10 * S, 1, 0);
        cap.delete();
        pixelReq = 1; wrValid = 1; wrAddr = AW'(10); wrData = 3'h7;
        tick();
        idle_in();
        repeat (3) tick();
        chk("collide_old", cap[0], 1);
        scan(10 * S + 1, 1, 0);
        chk("collide_new", cap[10 * S], 7);

        clearColor = 3'h3; clearReq = 1; tick(); clearReq = 0;
        repeat (100) tick();
        chk("midclear_busy", clearBusy, 1);
        reset = 1;
        #1 chk("midclear_rst_busy", clearBusy, 0);
        chk("midclear_rst_ready", wrReady, 0);
        tick(); tick();
        reset = 0;
        tick();
        chk("midclear_ready_after", wrReady, 1);
        chk("midclear_err_cleared", wrErr, 0);
        clear_run(5, busy_cnt, ready_hi);
        chk("reclear_busy_cycles", busy_cnt, DEPTH);
        chk("reclear_ready_low", ready_hi, 0);
        scan(FRAME, 1, 0);
        check_all("clear_fill_5", 5);

        for (int c = 0; c < 3000; c++) begin
            wrValid = 1'($urandom_range(0, 1));
            wrAddr = AW'($urandom_range(0, DEPTH + 15));
            wrData = PW'($urandom);
            pixelReq = ($urandom_range(0, 3) != 0);
            frameStart = ($urandom_range(0, 199) == 0);
            clearReq = ($urandom_range(0, 1499) == 0);
            clearColor = PW'($urandom);
            tick();
        end
        idle_in();
        repeat (3) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/frame_buffer_ctrl.md
Name: frame_buffer_ctrl

Overview:
Parametrised VGA frame buffer with write port, hardware clear engine and raster scan-out address generator. Replaces the fixed 17-bit-address / 3-bit-pixel test memory. The display timing block drives frameStart/pixelReq; the drawing logic writes pixels. Supports integer pixel replication (SCALE) so a 320x240 buffer can drive a 640x480 raster.

Parameters:
H_RES, 320, buffer width in pixels
V_RES, 240, buffer height in pixels
PIX_W, 3, bits per pixel (RGB)
ADDR_W, 17, address width; must satisfy 2**ADDR_W >= H_RES*V_RES
SCALE, 2, pixel/line replication factor (1..4)

Ports:
clock  in  1  system clock, all logic on rising edge
reset  in  1  asynchronous, active-high reset
wrValid  in  1  write request
wrReady  out  1  write accepted when wrValid&&wrReady
wrAddr  in  ADDR_W  linear write address (row*H_RES+col)
wrData  in  PIX_W  pixel to write
wrErr  out  1  sticky: accepted write had wrAddr >= DEPTH
clearReq  in  1  single-cycle pulse: fill buffer with clearColor
clearColor  in  PIX_W  fill value, sampled with clearReq
clearBusy  out  1  high while clear in progress
frameStart  in  1  pulse: restart scan at pixel (0,0)
pixelReq  in  1  one per displayed raster pixel
pixelOut  out  PIX_W  scanned pixel
pixelValid  out  1  pixelOut valid this cycle

Behaviour:
- DEPTH = H_RES*V_RES. Storage: inferred simple dual-port RAM, one write port, one registered read port; read-first on same-address collision (old data returned).
- Reset values: wrReady 0 (goes 1 first cycle after reset release), wrErr 0, clearBusy 0, pixelOut 0, pixelValid 0, all scan counters 0, FSM IDLE. RAM contents not reset.
- Write FSM: IDLE, CLEAR.
  - IDLE: wrReady=1; accepted write stores wrData at wrAddr if wrAddr < DEPTH, else dropped and wrErr set (sticky until reset). clearReq -> CLEAR next cycle, latch clearColor, clrAddr=0; a write accepted in the same cycle as clearReq still completes.
  - CLEAR: wrReady=0, clearBusy=1; write latched color to clrAddr each cycle, clrAddr++; after writing DEPTH-1 -> IDLE. Exactly DEPTH cycles in CLEAR. clearReq during CLEAR ignored.
- Scan counters: subX (0..SCALE-1), col (0..H_RES-1), subY (0..SCALE-1), row (0..V_RES-1), lineBase = row*H_RES (maintained by addition, no multiplier).
  - Each pixelReq reads lineBase+col, then advances: subX++; at SCALE-1 wrap subX, col++; at col H_RES-1 wrap col, subY++; at subY SCALE-1 wrap subY, row++, lineBase+=H_RES; at row V_RES-1 wrap to row 0, lineBase 0 (free-running if frameStart absent).
  - frameStart: counters forced to 0; if pixelReq is in the same cycle, that request reads address 0 and counters advance from 0.
- Read latency: pixelValid = pixelReq delayed 1 cycle; pixelOut updates only when pixelValid, otherwise holds.
- Scan reads are independent of writes/clear; clear is visible on screen as it progresses.
- Reset mid-clear: FSM to IDLE immediately, buffer partially cleared (contents defined only at written addresses).

Decomposition:
- Package fb_pkg: localparam helpers (DEPTH function, ADDR_W check), typedef enum {IDLE, CLEAR} fb_state_t, typedef logic [PIX_W-1:0] pixel_t is parameter-dependent so stays local.
- Sub-module fb_dpram (parametrised simple dual-port RAM, registered read, read-first). Scan generator and write FSM stay in frame_buffer_ctrl.

Test Plan:
- Reset, write 0x5 to addr 0 and 0x3 to addr 321, frameStart, SCALE=2 -> pixelOut seq at raster x=0,1 = 5,5; line 2 (raster y=2) x=2,3 = 3,3; pixelValid 1 cycle after each pixelReq.
- clearReq with clearColor=0x2 -> clearBusy high exactly 76800 cycles, wrReady 0 throughout; full scan then returns 0x2 at every pixel.
- Write addr 76800 (out of range) -> handshake completes, wrErr=1 and stays 1; addr 0 unchanged.
- frameStart coincident with pixelReq mid-frame (col 100, row 50) -> that request returns addr 0 data; next two requests (SCALE=2) return addr 0 then addr 1.
- Same-cycle write 0x7 and scan read of addr 10 holding 0x1 -> pixelOut 0x1; next frame returns 0x7.
- Assert reset 1000 cycles into clear -> clearBusy 0 next edge, wrReady 1 after release; new clearReq runs full DEPTH cycles.
